xif_coproc_mac: RTL

Coprocessor-side responder for the CORE-V-XIF issue, commit and result channels. It sits opposite the CPU's XIF wrapper on the shared XIF bus and implements a signed multiply-accumulate accelerator with one architectural 32-bit accumulator. It handles one instruction in flight at a time. Accumulator updates are speculative-safe: they happen only after a non-killed commit.

---
 rtl/xif_coproc_mac_pkg.sv | 48 ++++
 rtl/xif_coproc_mac_unit.sv | 81 ++++++++
 rtl/xif_coproc_mac.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/xif_coproc_mac_pkg.sv
// Shared types and constants for the XIF multiply-accumulate coprocessor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xif_coproc_mac_pkg;

    // Custom-0 major opcode claimed by default.
    localparam logic [6:0] OPCODE_DEF = 7'h0B;

    localparam logic [2:0] FUNCT3_MAC = 3'd0;
    localparam logic [2:0] FUNCT3_CLR = 3'd1;
    localparam logic [2:0] FUNCT3_RD  = 3'd2;

    typedef enum logic [1:0] {
        OP_MAC,
        OP_CLR,
        OP_RD
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COMMIT,
        EXEC,
        RESULT
    } state_e;

    // Everything kept from the issue handshake until the result retires.
    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } instr_t;

    localparam logic signed [63:0] SAT_MAX64 = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN64 = 64'shFFFF_FFFF_8000_0000;

    // Clamp a 64-bit signed value into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        if (v > SAT_MAX64) begin
            return 32'h7FFF_FFFF;
        end else if (v < SAT_MIN64) begin
            return 32'h8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/xif_coproc_mac_unit.sv
// Signed multiply-add datapath: rs1*rs2 pipelined, then added to the accumulator.
// Latency: product reaches the adder MUL_LAT-1 cycles after operands are presented; add is combinational.
// Backpressure: none; free-running pipeline, the owner samples mac_o when its counter expires.
// Ports: clk_i/rst_i; rs1_i, rs2_i operands (held stable by the owner); acc_i current accumulator;
//        mac_o = acc_i + product. XIF_COPROC_SAT_EN selects saturating product and add.
module xif_coproc_mac_unit
    import xif_coproc_mac_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] acc_i,
    output logic [31:0] mac_o
);

    logic signed [63:0] rs1_ext;
    logic signed [63:0] rs2_ext;
    logic signed [63:0] prod_s;
    logic        [31:0] prod_narrow;
    logic        [31:0] prod_late;
    logic               unused_prod_hi;

    assign rs1_ext = {{32{rs1_i[31]}}, rs1_i};
    assign rs2_ext = {{32{rs2_i[31]}}, rs2_i};
    assign prod_s  = rs1_ext * rs2_ext;

    // Only the low word matters in wrap mode; in saturating mode sat32 reads all of it.
    assign unused_prod_hi = ^prod_s[63:32];

`ifdef XIF_COPROC_SAT_EN
    assign prod_narrow = sat32(prod_s);
`else
    assign prod_narrow = prod_s[31:0];
`endif

    // The FSM holds operands stable from the issue handshake onward, so a plain
    // delay line of MUL_LAT-1 registers is enough to line the product up with
    // the last EXEC cycle.
    generate
        if (MUL_LAT > 1) begin : g_pipe
            logic [31:0] stage_q [MUL_LAT-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < MUL_LAT - 1; k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q[0] <= prod_narrow;
                    for (int k = 1; k < MUL_LAT - 1; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign prod_late = stage_q[MUL_LAT-2];
        end else begin : g_nopipe
            assign prod_late = prod_narrow;
        end
    endgenerate

`ifdef XIF_COPROC_SAT_EN
    logic [32:0] sum_wide;

    // Overflow shows up as a disagreement between the sign bit and the guard bit.
    always_comb begin
        sum_wide = {acc_i[31], acc_i} + {prod_late[31], prod_late};
        if (sum_wide[32] != sum_wide[31]) begin
            mac_o = sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            mac_o = sum_wide[31:0];
        end
    end
`else
    assign mac_o = acc_i + prod_late;
`endif

endmodule

// File: rtl/xif_coproc_mac.sv
// CORE-V-XIF coprocessor responder: signed MAC into one 32-bit accumulator, one instruction in flight.
// Latency: first result_valid_o MUL_LAT+1 cycles after the non-killed commit cycle.
// Backpressure: issue_ready_o only in IDLE (MAC also needs both operands valid); result held until result_ready_i.
// Ports: clk_i/rst_i (sync, active-high); issue_* request/response; commit_* commit/kill;
//        result_* writeback channel. Optional build macro XIF_COPROC_SAT_EN enables saturating MAC.
module xif_coproc_mac
    import xif_coproc_mac_pkg::*;
#(
    parameter int         ID_W    = 4,
    parameter int         MUL_LAT = 2,
    parameter logic [6:0] OPCODE  = OPCODE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [31:0]          issue_instr_i,
    input  logic [ID_W-1:0]      issue_id_i,
    input  logic [1:0][31:0]     issue_rs_i,
    input  logic [1:0]           issue_rs_valid_i,
    output logic                 issue_accept_o,
    output logic                 issue_writeback_o,
    input  logic                 commit_valid_i,
    input  logic [ID_W-1:0]      commit_id_i,
    input  logic                 commit_kill_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [ID_W-1:0]      result_id_o,
    output logic [31:0]          result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o
);

    localparam int         CNT_W    = 2;
    localparam logic [1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    state_e          state_q, state_d;
    instr_t          instr_q, instr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     res_q, res_d;

    logic            dec_hit;
    op_e             dec_op;
    logic [4:0]      dec_rd;
    logic [31:0]     mac_sum;
    logic            unused_instr;

    assign dec_rd       = issue_instr_i[11:7];
    assign unused_instr = ^issue_instr_i[31:15];

    always_comb begin
        dec_hit = 1'b0;
        dec_op  = OP_MAC;
        if (issue_instr_i[6:0] == OPCODE) begin
            case (issue_instr_i[14:12])
                FUNCT3_MAC: begin dec_hit = 1'b1; dec_op = OP_MAC; end
                FUNCT3_CLR: begin dec_hit = 1'b1; dec_op = OP_CLR; end
                FUNCT3_RD:  begin dec_hit = 1'b1; dec_op = OP_RD;  end
                default:    begin dec_hit = 1'b0; dec_op = OP_MAC; end
            endcase
        end
    end

    xif_coproc_mac_unit #(
        .MUL_LAT (MUL_LAT)
    ) u_unit (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rs1_i (instr_q.rs1),
        .rs2_i (instr_q.rs2),
        .acc_i (acc_q),
        .mac_o (mac_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            instr_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // All outputs are forced low while rst_i is asserted.
    always_comb begin
        state_d           = state_q;
        instr_d           = instr_q;
        id_d              = id_q;
        cnt_d             = cnt_q;
        acc_d             = acc_q;
        res_d             = res_q;
        issue_ready_o     = 1'b0;
        issue_accept_o    = 1'b0;
        issue_writeback_o = 1'b0;
        result_valid_o    = 1'b0;
        result_id_o       = '0;
        result_data_o     = '0;
        result_rd_o       = '0;
        result_we_o       = 1'b0;

        if (!rst_i) begin
            issue_accept_o    = dec_hit;
            issue_writeback_o = dec_hit && (dec_rd != 5'd0);
        end

        case (state_q)
            IDLE: begin
                issue_ready_o = !rst_i &&
                                (!(dec_hit && dec_op == OP_MAC) || (&issue_rs_valid_i));
                // A rejected instruction still handshakes but leaves us in IDLE.
                if (issue_valid_i && issue_ready_o && dec_hit) begin
                    state_d       = WAIT_COMMIT;
                    instr_d.op    = dec_op;
                    instr_d.rd    = dec_rd;
                    instr_d.rs1   = issue_rs_i[0];
                    instr_d.rs2   = issue_rs_i[1];
                    id_d          = issue_id_i;
                end
            end
            WAIT_COMMIT: begin
                if (commit_valid_i && commit_id_i == id_q) begin
                    if (commit_kill_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            EXEC: begin
                // CLR and RD also wait out the counter so every op has the same latency.
                if (cnt_q == 2'd0) begin
                    state_d = RESULT;
                    case (instr_q.op)
                        OP_MAC: begin
                            acc_d = mac_sum;
                            res_d = mac_sum;
                        end
                        OP_CLR: begin
                            acc_d = '0;
                            res_d = acc_q;
                        end
                        default: begin
                            res_d = acc_q;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESULT: begin
                if (!rst_i) begin
                    result_valid_o = 1'b1;
                    result_id_o    = id_q;
                    result_data_o  = res_q;
                    result_rd_o    = instr_q.rd;
                    result_we_o    = (instr_q.rd != 5'd0);
                end
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
